// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: steps a 10-bit duty word toward a commanded target at a
// programmable update rate. Mode 0 ramps once and pulses done on arrival;
// mode 1 breathes between 0 and the target until stopped.
module pwm_duty_ramp #(
  parameter int unsigned TICK_DIV = 100_000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic [9:0] target_i,
  input  logic [5:0] step_i,
  input  logic       stop_i,
  output logic [9:0] duty_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RAMP    = 2'd1,
    S_BR_UP   = 2'd2,
    S_BR_DOWN = 2'd3
  } state_e;

  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

  // Unsigned add with a carry bit, clamped to lim before truncation.
  function automatic logic [9:0] sat_add(input logic [9:0] a,
                                         input logic [5:0] s,
                                         input logic [9:0] lim);
    logic [10:0] sum;
    sum = {1'b0, a} + {5'b00000, s};
    if (sum > {1'b0, lim}) begin
      return lim;
    end else begin
      return sum[9:0];
    end
  endfunction

  // Unsigned subtract with a borrow bit, clamped to lim before truncation.
  function automatic logic [9:0] sat_sub(input logic [9:0] a,
                                         input logic [5:0] s,
                                         input logic [9:0] lim);
    logic [10:0] diff;
    diff = {1'b0, a} - {5'b00000, s};
    if (diff[10] || (diff[9:0] < lim)) begin
      return lim;
    end else begin
      return diff[9:0];
    end
  endfunction

  state_e      state_q, state_d;
  logic [9:0]  duty_q, duty_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        done_pend_q, done_pend_d;
  logic        mode_q, mode_d;
  logic [9:0]  target_q, target_d;
  logic [5:0]  step_q, step_d;
  logic [31:0] cnt_q, cnt_d;

  logic        tick_s;
  logic [9:0]  up_next_s;
  logic [9:0]  dn_next_s;
  logic [9:0]  dn_zero_s;

  assign tick_s    = (state_q != S_IDLE) && (cnt_q == TICK_LAST);
  assign up_next_s = sat_add(duty_q, step_q, target_q);
  assign dn_next_s = sat_sub(duty_q, step_q, target_q);
  assign dn_zero_s = sat_sub(duty_q, step_q, 10'd0);

  // Next-state, duty update, command latching and tick counter control.
  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    done_d      = 1'b0;
    done_pend_d = 1'b0;
    mode_d      = mode_q;
    target_d    = target_q;
    step_d      = step_q;

    case (state_q)
      S_IDLE: begin
        // A start that found duty already at target reports done one cycle later.
        done_d = done_pend_q;
        if (start_i && !stop_i) begin
          mode_d   = mode_i;
          target_d = target_i;
          step_d   = (step_i == 6'd0) ? 6'd1 : step_i;
          if (!mode_i) begin
            if (duty_q == target_i) begin
              done_pend_d = 1'b1;
            end else begin
              state_d = S_RAMP;
            end
          end else if (duty_q < target_i) begin
            state_d = S_BR_UP;
          end else begin
            state_d = S_BR_DOWN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RAMP: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (tick_s) begin
          if (duty_q < target_q) begin
            duty_d = up_next_s;
          end else begin
            duty_d = dn_next_s;
          end
          if (duty_d == target_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RAMP;
          end
        end else begin
          state_d = S_RAMP;
        end
      end
      S_BR_UP: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (tick_s) begin
          duty_d = up_next_s;
          if (up_next_s == target_q) begin
            state_d = S_BR_DOWN;
          end else begin
            state_d = S_BR_UP;
          end
        end else begin
          state_d = S_BR_UP;
        end
      end
      S_BR_DOWN: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (tick_s) begin
          duty_d = dn_zero_s;
          if (dn_zero_s == 10'd0) begin
            state_d = S_BR_UP;
          end else begin
            state_d = S_BR_DOWN;
          end
        end else begin
          state_d = S_BR_DOWN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Counter restarts at every entry to or exit from a busy state.
    if ((state_d == S_IDLE) || (state_q == S_IDLE)) begin
      cnt_d = 32'd0;
    end else if (tick_s) begin
      cnt_d = 32'd0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and registered outputs with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      duty_q      <= 10'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_pend_q <= 1'b0;
      mode_q      <= 1'b0;
      target_q    <= 10'd0;
      step_q      <= 6'd1;
      cnt_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_pend_q <= done_pend_d;
      mode_q      <= mode_d;
      target_q    <= target_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
    end
  end

  assign duty_o = duty_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
